uart_command_framer: RTL

- Sits directly downstream of the UART receiver; consumes its one-cycle `has_data` strobe and `data_received` byte.
- Assembles two consecutive bytes (command, then sensor address) into one request.
- Range-checks both bytes and an inter-byte timeout, then presents the request with a valid/ready handshake to the sensor controller.
- Protocol errors are reported as one-cycle pulses with an error code.

---
 rtl/uart_command_framer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_command_framer.sv
//============================================================================
// Module   : uart_command_framer
// Purpose  : Collects a command byte and a sensor-address byte from the UART
//            receiver. It range-checks both bytes and the inter-byte gap, then
//            offers the request downstream through a valid/ready handshake.
//            Protocol faults are reported as one-cycle error pulses, each
//            with an error code that persists until the next fault.
// Revision : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_command_framer #(
    parameter int         TIMEOUT_CYCLES = 8680,
    parameter logic [7:0] MAX_COMMAND    = 8'h06,
    parameter int         NUM_SENSORS    = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       has_data,
    input  logic [7:0] data_received,
    input  logic       request_ready,
    output logic       request_valid,
    output logic [7:0] request_command,
    output logic [7:0] request_address,
    output logic       error,
    output logic [2:0] error_code,
    output logic [1:0] debug_state
);

    // Counter only has to reach TIMEOUT_CYCLES-1
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_ADDR = 2'd1;
    localparam logic [1:0] S_VALIDATE  = 2'd2;
    localparam logic [1:0] S_HOLD      = 2'd3;

    localparam logic [2:0] C_ERR_TIMEOUT     = 3'd1;
    localparam logic [2:0] C_ERR_BAD_COMMAND = 3'd2;
    localparam logic [2:0] C_ERR_BAD_ADDRESS = 3'd3;
    localparam logic [2:0] C_ERR_OVERRUN     = 3'd4;

    localparam logic [CW-1:0] C_LAST_COUNT  = CW'(TIMEOUT_CYCLES - 1);
    // Nine bits so that NUM_SENSORS == 256 still compares correctly
    localparam logic [8:0]    C_NUM_SENSORS = 9'(NUM_SENSORS);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [CW-1:0] r_count;
    logic [7:0]    r_cmd_byte;
    logic [7:0]    r_addr_byte;
    logic          r_req_valid;
    logic [7:0]    r_req_cmd;
    logic [7:0]    r_req_addr;
    logic          r_error;
    logic [2:0]    r_error_code;

    logic          w_bad_cmd;
    logic          w_bad_addr;
    logic          w_timeout;
    logic          w_capture_cmd;
    logic          w_capture_addr;
    logic          w_load_req;
    logic          w_clear_valid;
    logic          w_error;
    logic [2:0]    w_error_code;

    assign w_bad_cmd  = (r_cmd_byte > MAX_COMMAND);
    assign w_bad_addr = ({1'b0, r_addr_byte} >= C_NUM_SENSORS);
    assign w_timeout  = (r_count == C_LAST_COUNT);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; an address strobe beats a same-cycle timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (has_data) w_next_state = S_WAIT_ADDR;
            end
            S_WAIT_ADDR: begin
                if (has_data)       w_next_state = S_VALIDATE;
                else if (w_timeout) w_next_state = S_IDLE;
            end
            S_VALIDATE: begin
                if (w_bad_cmd || w_bad_addr) w_next_state = S_IDLE;
                else                         w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (request_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output/control decode; a validation failure masks a same-cycle overrun
    always_comb begin
        w_capture_cmd  = 1'b0;
        w_capture_addr = 1'b0;
        w_load_req     = 1'b0;
        w_clear_valid  = 1'b0;
        w_error        = 1'b0;
        w_error_code   = 3'd0;
        case (r_state)
            S_IDLE: begin
                w_capture_cmd = has_data;
            end
            S_WAIT_ADDR: begin
                w_capture_addr = has_data;
                if (!has_data && w_timeout) begin
                    w_error      = 1'b1;
                    w_error_code = C_ERR_TIMEOUT;
                end
            end
            S_VALIDATE: begin
                if (w_bad_cmd) begin
                    w_error      = 1'b1;
                    w_error_code = C_ERR_BAD_COMMAND;
                end else if (w_bad_addr) begin
                    w_error      = 1'b1;
                    w_error_code = C_ERR_BAD_ADDRESS;
                end else begin
                    w_load_req = 1'b1;
                    if (has_data) begin
                        w_error      = 1'b1;
                        w_error_code = C_ERR_OVERRUN;
                    end
                end
            end
            S_HOLD: begin
                w_clear_valid = request_ready;
                if (has_data) begin
                    w_error      = 1'b1;
                    w_error_code = C_ERR_OVERRUN;
                end
            end
            default: begin
                w_error = 1'b0;
            end
        endcase
    end

    // Inter-byte timer: runs only while waiting for the address, never wraps
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (r_state == S_WAIT_ADDR) begin
            if (r_count != C_LAST_COUNT) r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

    // Frame bytes, request outputs and error reporting
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cmd_byte   <= 8'd0;
            r_addr_byte  <= 8'd0;
            r_req_valid  <= 1'b0;
            r_req_cmd    <= 8'd0;
            r_req_addr   <= 8'd0;
            r_error      <= 1'b0;
            r_error_code <= 3'd0;
        end else begin
            if (w_capture_cmd)  r_cmd_byte  <= data_received;
            if (w_capture_addr) r_addr_byte <= data_received;
            if (w_load_req) begin
                r_req_valid <= 1'b1;
                r_req_cmd   <= r_cmd_byte;
                r_req_addr  <= r_addr_byte;
            end else if (w_clear_valid) begin
                r_req_valid <= 1'b0;
            end
            r_error <= w_error;
            if (w_error) r_error_code <= w_error_code;
        end
    end

    assign request_valid   = r_req_valid;
    assign request_command = r_req_cmd;
    assign request_address = r_req_addr;
    assign error           = r_error;
    assign error_code      = r_error_code;
    assign debug_state     = r_state;

endmodule

`default_nettype wire
